// File: rtl/alu.sv
// Single-cycle MIPS-style ALU: combinational decode/compute of one instruction word,
// with result and flags captured in output registers on every rising clock.
module alu (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instruction,
  input  logic [31:0] regA,
  input  logic [31:0] regB,
  output logic [31:0] result,
  output logic [2:0]  flags
);

  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  shamt;
  logic [15:0] imm;
  logic [31:0] op_x;
  logic [31:0] op_y;
  logic [31:0] sign_ext;
  logic [31:0] zero_ext;
  logic [31:0] sum;
  logic [31:0] diff;
  logic [31:0] sum_imm;
  logic        add_ovf;
  logic        sub_ovf;
  logic        addi_ovf;
  logic        lt_s;
  logic        lt_u;
  logic        lti_s;
  logic        lti_u;
  logic        eq;

  logic [31:0] result_d, result_q;
  logic [2:0]  flags_d, flags_q;

  assign opcode = instruction[31:26];
  assign funct  = instruction[5:0];
  assign rs     = instruction[25:21];
  assign rt     = instruction[20:16];
  assign shamt  = instruction[10:6];
  assign imm    = instruction[15:0];

  // A zero register index selects regA, any other index selects regB.
  assign op_x = (rs == 5'd0) ? regA : regB;
  assign op_y = (rt == 5'd0) ? regA : regB;

  assign sign_ext = {{16{imm[15]}}, imm};
  assign zero_ext = {16'h0000, imm};

  assign sum     = op_x + op_y;
  assign diff    = op_x - op_y;
  assign sum_imm = op_x + sign_ext;

  // Signed overflow: operands agree in sign (add) or differ (sub) and the result sign flips.
  assign add_ovf  = (op_x[31] == op_y[31])     && (sum[31]     != op_x[31]);
  assign sub_ovf  = (op_x[31] != op_y[31])     && (diff[31]    != op_x[31]);
  assign addi_ovf = (op_x[31] == sign_ext[31]) && (sum_imm[31] != op_x[31]);

  assign lt_s  = $signed(op_x) < $signed(op_y);
  assign lt_u  = op_x < op_y;
  assign lti_s = $signed(op_x) < $signed(sign_ext);
  assign lti_u = op_x < sign_ext;
  assign eq    = (op_x == op_y);

  always_comb begin
    result_d = 32'h0;
    flags_d  = 3'b000;
    case (opcode)
      6'b000000: begin
        case (funct)
          6'b100000: begin result_d = sum;  flags_d[0] = add_ovf; end
          6'b100001: result_d = sum;
          6'b100010: begin result_d = diff; flags_d[0] = sub_ovf; end
          6'b100011: result_d = diff;
          6'b100100: result_d = op_x & op_y;
          6'b100101: result_d = op_x | op_y;
          6'b100110: result_d = op_x ^ op_y;
          6'b100111: result_d = ~(op_x | op_y);
          6'b101010: begin result_d = {31'h0, lt_s}; flags_d[1] = lt_s; end
          6'b101011: begin result_d = {31'h0, lt_u}; flags_d[1] = lt_u; end
          6'b000000: result_d = op_y << shamt;
          6'b000010: result_d = op_y >> shamt;
          6'b000011: result_d = $unsigned($signed(op_y) >>> shamt);
          6'b000100: result_d = op_y << op_x[4:0];
          6'b000110: result_d = op_y >> op_x[4:0];
          6'b000111: result_d = $unsigned($signed(op_y) >>> op_x[4:0]);
          default: ;
        endcase
      end
      6'b001000: begin result_d = sum_imm; flags_d[0] = addi_ovf; end
      6'b001001: result_d = sum_imm;
      6'b001100: result_d = op_x & zero_ext;
      6'b001101: result_d = op_x | zero_ext;
      6'b001110: result_d = op_x ^ zero_ext;
      6'b001010: begin result_d = {31'h0, lti_s}; flags_d[1] = lti_s; end
      6'b001011: begin result_d = {31'h0, lti_u}; flags_d[1] = lti_u; end
      6'b100011: result_d = sum_imm;
      6'b101011: result_d = sum_imm;
      6'b000100: begin result_d = {31'h0, eq};  flags_d[2] = eq; end
      6'b000101: begin result_d = {31'h0, !eq}; flags_d[2] = eq; end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      result_q <= 32'h0;
      flags_q  <= 3'b000;
    end else begin
      result_q <= result_d;
      flags_q  <= flags_d;
    end
  end

  assign result = result_q;
  assign flags  = flags_q;

endmodule

// File: tb/tb_alu.sv
// Scoreboard bench for alu: a driver pushes expected {result,flags} per issued instruction,
// a monitor pops and compares one cycle later; expectations come from directed constants or a reference model.
module tb_alu;

  logic        clk;
  logic        reset;
  logic [31:0] instruction;
  logic [31:0] regA;
  logic [31:0] regB;
  logic [31:0] result;
  logic [2:0]  flags;

  int n_compared;
  int n_mismatched;
  logic [34:0] exp_q[$];

  alu dut (
    .clk(clk),
    .reset(reset),
    .instruction(instruction),
    .regA(regA),
    .regB(regB),
    .result(result),
    .flags(flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] rType(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] sh, input logic [5:0] fn);
    return {6'b000000, rs, rt, 5'd0, sh, fn};
  endfunction

  function automatic logic [31:0] iType(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] im);
    return {op, rs, rt, im};
  endfunction

  // Reference model built from the instruction table using wide signed arithmetic.
  function automatic void refModel(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b,
                                   output logic [31:0] r, output logic [2:0] f);
    logic [5:0]  op;
    logic [5:0]  fn;
    logic [4:0]  sh;
    logic [4:0]  vs;
    logic [31:0] x;
    logic [31:0] y;
    logic [31:0] se;
    logic [31:0] ze;
    longint      sx;
    longint      sy;
    longint      sse;
    longint      uy;
    longint      t;
    op  = ins[31:26];
    fn  = ins[5:0];
    sh  = ins[10:6];
    x   = (ins[25:21] == 5'd0) ? a : b;
    y   = (ins[20:16] == 5'd0) ? a : b;
    sx  = longint'($signed(x));
    sy  = longint'($signed(y));
    sse = longint'($signed(ins[15:0]));
    se  = sse[31:0];
    ze  = {16'h0000, ins[15:0]};
    uy  = longint'({32'h0, y});
    vs  = x[4:0];
    r = 32'h0;
    f = 3'b000;
    if (op == 6'd0) begin
      case (fn)
        6'h20: begin t = sx + sy; r = t[31:0]; f[0] = (t > 64'sd2147483647) || (t < -64'sd2147483648); end
        6'h21: begin t = sx + sy; r = t[31:0]; end
        6'h22: begin t = sx - sy; r = t[31:0]; f[0] = (t > 64'sd2147483647) || (t < -64'sd2147483648); end
        6'h23: begin t = sx - sy; r = t[31:0]; end
        6'h24: r = x & y;
        6'h25: r = x | y;
        6'h26: r = x ^ y;
        6'h27: r = ~(x | y);
        6'h2A: begin f[1] = (sx < sy); r = {31'h0, f[1]}; end
        6'h2B: begin f[1] = (x < y); r = {31'h0, f[1]}; end
        6'h00: begin t = uy * (64'sd1 << sh); r = t[31:0]; end
        6'h02: begin t = uy / (64'sd1 << sh); r = t[31:0]; end
        6'h03: begin t = sy >>> sh; r = t[31:0]; end
        6'h04: begin t = uy * (64'sd1 << vs); r = t[31:0]; end
        6'h06: begin t = uy / (64'sd1 << vs); r = t[31:0]; end
        6'h07: begin t = sy >>> vs; r = t[31:0]; end
        default: ;
      endcase
    end else begin
      case (op)
        6'h08: begin t = sx + sse; r = t[31:0]; f[0] = (t > 64'sd2147483647) || (t < -64'sd2147483648); end
        6'h09, 6'h23, 6'h2B: begin t = sx + sse; r = t[31:0]; end
        6'h0C: r = x & ze;
        6'h0D: r = x | ze;
        6'h0E: r = x ^ ze;
        6'h0A: begin f[1] = (sx < sse); r = {31'h0, f[1]}; end
        6'h0B: begin f[1] = (x < se); r = {31'h0, f[1]}; end
        6'h04: begin f[2] = (x == y); r = {31'h0, f[2]}; end
        6'h05: begin f[2] = (x == y); r = {31'h0, !f[2]}; end
        default: ;
      endcase
    end
  endfunction

  task automatic applyStimulus(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] er, input logic [2:0] ef);
    @(negedge clk);
    instruction = ins;
    regA = a;
    regB = b;
    exp_q.push_back({er, ef});
  endtask

  task automatic applyModelled(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] er;
    logic [2:0]  ef;
    refModel(ins, a, b, er, ef);
    applyStimulus(ins, a, b, er, ef);
  endtask

  task automatic checkOutput(input string name, input logic [31:0] er, input logic [2:0] ef);
    n_compared++;
    if (result !== er || flags !== ef) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got result=%h flags=%b, expected result=%h flags=%b",
               name, result, flags, er, ef);
    end
  endtask

  // Monitor: one registered output per issued instruction, visible just after the edge.
  initial begin
    logic [34:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (!reset && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checkOutput("scoreboard", e[34:3], e[2:0]);
      end
    end
  end

  localparam logic [5:0] R_FN[16] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
                                      6'h2A, 6'h2B, 6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07};
  localparam logic [5:0] I_OP[11] = '{6'h08, 6'h09, 6'h0C, 6'h0D, 6'h0E, 6'h0A, 6'h0B,
                                      6'h23, 6'h2B, 6'h04, 6'h05};

  initial begin
    logic [31:0] ins;
    logic [31:0] a;
    logic [31:0] b;
    int          k;
    n_compared   = 0;
    n_mismatched = 0;
    reset        = 1'b1;
    instruction  = rType(5'd0, 5'd1, 5'd0, 6'h20);
    regA         = 32'h1234_5678;
    regB         = 32'h0000_0001;
    #2;
    checkOutput("reset_state", 32'h0, 3'b000);
    @(posedge clk);
    #1;
    checkOutput("reset_held_over_edge", 32'h0, 3'b000);
    @(negedge clk);
    reset = 1'b0;

    // Directed vectors with hand-derived expectations.
    applyStimulus(rType(5'd0, 5'd1, 5'd0, 6'h20), 32'hFFFF_FFFE, 32'h8000_0001, 32'h7FFF_FFFF, 3'b001);
    applyStimulus(iType(6'h08, 5'd1, 5'd0, 16'hFFFF), 32'h0, 32'h8000_0000, 32'h7FFF_FFFF, 3'b001);
    applyStimulus(iType(6'h09, 5'd0, 5'd0, 16'h0001), 32'hFFFF_FFFF, 32'h0, 32'h0, 3'b000);
    applyStimulus(iType(6'h0E, 5'd1, 5'd0, 16'hFFFF), 32'h0, 32'h0000_0C03, 32'h0000_F3FC, 3'b000);
    applyStimulus(iType(6'h0C, 5'd1, 5'd0, 16'hFFFE), 32'h0, 32'h0000_0C03, 32'h0000_0C02, 3'b000);
    applyStimulus(iType(6'h0B, 5'd0, 5'd1, 16'hFFFF), 32'h0000_0C03, 32'h0, 32'h1, 3'b010);
    applyStimulus(rType(5'd0, 5'd1, 5'd0, 6'h2B), 32'hFFFF_FFFF, 32'h0000_0C03, 32'h0, 3'b000);
    applyStimulus(iType(6'h04, 5'd0, 5'd1, 16'h0010), 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1, 3'b100);
    applyStimulus(iType(6'h05, 5'd0, 5'd1, 16'h0010), 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 3'b100);
    applyStimulus(rType(5'd0, 5'd1, 5'd1, 6'h03), 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'b000);
    applyStimulus(rType(5'd0, 5'd1, 5'd0, 6'h06), 32'h2, 32'hFFFF_FFFF, 32'h3FFF_FFFF, 3'b000);
    applyStimulus(rType(5'd0, 5'd1, 5'd1, 6'h00), 32'h0, 32'hDDDD_DDDD, 32'hBBBB_BBBA, 3'b000);
    applyStimulus(rType(5'd0, 5'd1, 5'd0, 6'h22), 32'h8000_0000, 32'h1, 32'h7FFF_FFFF, 3'b001);
    applyStimulus(rType(5'd0, 5'd1, 5'd0, 6'h23), 32'h8000_0000, 32'h1, 32'h7FFF_FFFF, 3'b000);
    applyStimulus(rType(5'd0, 5'd1, 5'd0, 6'h21), 32'hFFFF_FFFE, 32'h8000_0001, 32'h7FFF_FFFF, 3'b000);
    applyStimulus(rType(5'd0, 5'd1, 5'd0, 6'h2A), 32'hFFFF_FFFF, 32'h0000_0C03, 32'h1, 3'b010);
    applyStimulus(rType(5'd3, 5'd1, 5'd0, 6'h3F), 32'hFFFF_FFFF, 32'h1234_5678, 32'h0, 3'b000);
    applyStimulus(iType(6'h3F, 5'd3, 5'd1, 16'hFFFF), 32'hFFFF_FFFF, 32'h1234_5678, 32'h0, 3'b000);

    // Reset mid-stream: a registered nonzero value and a pending instruction are both dropped.
    applyStimulus(rType(5'd0, 5'd1, 5'd0, 6'h25), 32'h00F0_0000, 32'h0000_000F, 32'h00F0_000F, 3'b000);
    @(negedge clk);
    instruction = iType(6'h0D, 5'd1, 5'd0, 16'h00AA);
    regA = 32'h0;
    regB = 32'h5500_0000;
    #2;
    reset = 1'b1;
    #1;
    checkOutput("async_reset_clears", 32'h0, 3'b000);
    @(posedge clk);
    #1;
    checkOutput("reset_blocks_capture", 32'h0, 3'b000);
    @(negedge clk);
    reset = 1'b0;
    exp_q.push_back({32'h5500_00AA, 3'b000});

    // Randomized traffic against the reference model.
    for (int i = 0; i < 400; i++) begin
      k = $urandom_range(0, 9);
      ins = $urandom;
      if (k < 5) begin
        ins[31:26] = 6'd0;
        ins[5:0]   = R_FN[$urandom_range(0, 15)];
      end else if (k < 9) begin
        ins[31:26] = I_OP[$urandom_range(0, 10)];
      end
      if ($urandom_range(0, 1) == 0) ins[25:21] = 5'd0;
      if ($urandom_range(0, 1) == 0) ins[20:16] = 5'd0;
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 5))
        0: b = a;
        1: begin a = {1'b1, a[30:0]}; b = {1'b1, b[30:0]}; end
        2: begin a = a & 32'h8000_001F; b = b | 32'h7FFF_0000; end
        default: ;
      endcase
      applyModelled(ins, a, b);
    end

    @(posedge clk);
    @(posedge clk);
    #2;
    n_compared++;
    if (exp_q.size() != 0) begin
      n_mismatched++;
      $display("[TB] FAIL scoreboard_drained: got %0d pending, expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/alu.md
ALU -- requirements
Module: alu

Interface
REQ-001 Parameters: none; all widths fixed.
REQ-002 clk  input  1  rising-edge clock for the output registers.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 instruction  input  32  MIPS-format instruction word.
REQ-005 regA  input  32  operand register A.
REQ-006 regB  input  32  operand register B.
REQ-007 result  output  32  registered ALU result.
REQ-008 flags  output  3  registered flags:
- flags[2] = zero
- flags[1] = negative/less
- flags[0] = overflow

Function
REQ-009 The block SHALL expose hierarchically visible internal signals:
- opcode = instruction[31:26]
- funct = instruction[5:0]
REQ-010 Field decode SHALL be:
- rs = instruction[25:21]
- rt = instruction[20:16]
- shamt = instruction[10:6]
- imm = instruction[15:0]
REQ-011 Operand select SHALL be:
- opX = regA when rs==0, else regB
- opY = regA when rt==0, else regB
REQ-012 Immediate extension:
- signExt(imm) for addi, addiu, slti, sltiu, lw, sw
- zeroExt(imm) for andi, ori, xori
REQ-013 R-type (opcode 000000) by funct:
- add 100000: opX+opY
- addu 100001: opX+opY
- sub 100010: opX-opY
- subu 100011: opX-opY
- and 100100: opX&opY
- or 100101: opX|opY
- xor 100110: opX^opY
- nor 100111: ~(opX|opY)
- slt 101010: signed opX<opY ? 1 : 0
- sltu 101011: unsigned opX<opY ? 1 : 0
- sll 000000: opY<<shamt
- srl 000010: opY>>shamt (logical)
- sra 000011: opY>>>shamt (arithmetic)
- sllv 000100: opY<<opX[4:0]
- srlv 000110: opY>>opX[4:0] (logical)
- srav 000111: opY>>>opX[4:0] (arithmetic)
REQ-014 I-type by opcode:
- addi 001000, addiu 001001: opX+ext
- andi 001100: opX&ext
- ori 001101: opX|ext
- xori 001110: opX^ext
- slti 001010: signed opX<ext ? 1 : 0
- sltiu 001011: unsigned opX<ext ? 1 : 0
- lw 100011, sw 101011: opX+ext (address)
REQ-015 Branches:
- beq 000100: result = 1 if opX==opY, else 0
- bne 000101: result = 1 if opX!=opY, else 0
REQ-016 All arithmetic is 32-bit modulo 2^32; on overflow, result SHALL still be the wrapped value.
REQ-017 flags[0] SHALL be 1 only for add, addi, sub when signed overflow occurs; 0 for every other operation, including addu, addiu, subu.
REQ-018 flags[2] SHALL be 1 for beq/bne when opX==opY; 0 otherwise.
REQ-019 flags[1] SHALL equal the comparison outcome for slt, sltu, slti, sltiu; 0 otherwise.
REQ-020 Unsupported opcode/funct: result = 0, flags = 000.
REQ-021 Compute is combinational; result and flags SHALL be registered on rising clk, so latency = 1 cycle, one new instruction accepted every cycle, no handshake.

Reset
REQ-022 While reset=1, result and flags SHALL be 0 immediately, independent of clk.
REQ-023 The first capture after reset SHALL occur on the first rising clk with reset=0; reset asserted mid-operation discards the pending value.

Verification
REQ-024 add, rs=0 rt=1, regA=0xFFFFFFFE, regB=0x80000001 -> result 0x7FFFFFFF, flags[0]=1 after one clk.
REQ-025 addi, rs=1, imm=0xFFFF, regB=0x80000000 -> result 0x7FFFFFFF, flags[0]=1; addiu, rs=0, imm=1, regA=0xFFFFFFFF -> result 0, flags[0]=0.
REQ-026 Logic immediates, rs=1, regB=0xC03:
- xori imm=0xFFFF -> 0xF3FC
- andi imm=0xFFFE -> 0xC02
REQ-027 Compares, rs=0 rt=1:
- sltiu, regA=0xC03, imm=0xFFFF -> 1
- sltu, regA=0xFFFFFFFF, regB=0xC03 -> 0
- beq, regA=regB=0xFFFFFFFF -> 1, flags[2]=1
REQ-028 Shifts, regB=0xFFFFFFFF:
- sra shamt=1 -> 0xFFFFFFFF
- srlv with regA=2 -> 0x3FFFFFFF
- sll shamt=1, regB=0xDDDDDDDD -> 0xBBBBBBBA
REQ-029 Assert reset mid-stream -> result=0, flags=000 without waiting for a clk edge; release -> next edge captures the new value.
